cube_block_acc: RTL

- Downstream consumer of the signed-cube pipeline stage.
- Takes a stream of signed DW-bit cube values through a valid/ready handshake.
- Accumulates blocks of 2^N_LOG2 samples and presents per-block sum, floor-mean and signed maximum on an output valid/ready handshake.
- Sits between the cube stage and any result sink or monitor logic.

---
 rtl/cube_block_acc.sv | 114 +++++++++++
 1 files changed

// File: rtl/cube_block_acc.sv
// Block accumulator for the signed-cube stream: sums 2^N_LOG2 samples and
// presents sum, floor-mean and signed maximum, held until the sink accepts.
module cube_block_acc #(
  parameter int DW     = 12,
  parameter int N_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW+N_LOG2-1:0] out_sum,
  output logic [DW-1:0]        out_mean,
  output logic [DW-1:0]        out_max
);

  localparam int SW = DW + N_LOG2;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [N_LOG2-1:0]     count_q, count_d;
  logic signed [SW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  max_q, max_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic signed [DW-1:0]  mean_q, mean_d;
  logic signed [DW-1:0]  maxo_q, maxo_d;

  logic signed [DW-1:0]  sample;
  logic signed [SW-1:0]  sample_ext;
  logic signed [SW-1:0]  sum_new;
  logic signed [DW-1:0]  max_new;
  logic signed [DW-1:0]  mean_new;
  logic                  accept;
  logic                  last;

  // Handshake flags are pure state decodes: no combinational path from out_ready.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);

  assign out_sum  = sum_q;
  assign out_mean = mean_q;
  assign out_max  = maxo_q;

  assign sample     = $signed(in_data);
  assign sample_ext = SW'(sample);
  assign sum_new    = acc_q + sample_ext;
  assign max_new    = ((count_q == '0) || (sample > max_q)) ? sample : max_q;
  // Arithmetic shift gives floor division; the quotient always fits DW bits.
  assign mean_new   = DW'(sum_new >>> N_LOG2);
  assign accept     = in_valid && in_ready;
  assign last       = (count_q == {N_LOG2{1'b1}});

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    max_d   = max_q;
    sum_d   = sum_q;
    mean_d  = mean_q;
    maxo_d  = maxo_q;

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          max_d = max_new;
          if (last) begin
            sum_d   = sum_new;
            mean_d  = mean_new;
            maxo_d  = max_new;
            acc_d   = '0;
            count_d = '0;
            state_d = ST_HOLD;
          end else begin
            acc_d   = sum_new;
            count_d = count_q + N_LOG2'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACC;
      count_q <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      mean_q  <= '0;
      maxo_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      mean_q  <= mean_d;
      maxo_q  <= maxo_d;
    end
  end

endmodule
